// File: rtl/ahbl_apb_pkg.sv
// Shared types and AHB encodings for the AHB-Lite to APB3 bridge.
package ahbl_apb_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WDAT   = 3'd1,
        SETUP  = 3'd2,
        ACCESS = 3'd3,
        ERR1   = 3'd4,
        ERR2   = 3'd5
    } state_e;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_WORD = 3'b010;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

endpackage

// File: rtl/apb_timeout_timer.sv
// Saturating cycle counter that flags the last permitted ACCESS cycle; TIMEOUT=0 never expires.
module apb_timeout_timer #(
    parameter int TIMEOUT = 256
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] SAT  = CW'(TIMEOUT);
    localparam logic [CW-1:0] LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && cnt_q != SAT) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (TIMEOUT > 0) && (cnt_q == LAST);

endmodule

// File: rtl/ahbl_apb_bridge.sv
// AHB-Lite slave that runs one APB3 transfer per accepted AHB transfer, stretching the data
// phase with HREADYOUT and reporting PSLVERR, timeout or illegal requests as a two-cycle ERROR.
module ahbl_apb_bridge
    import ahbl_apb_pkg::*;
#(
    parameter int PADDR_WIDTH = 12,
    parameter int SELW        = 4,
    parameter int NSLAVE      = 16,
    parameter int TIMEOUT     = 256
) (
    input  logic                   HCLK,
    input  logic                   HRESET,
    input  logic                   HSEL,
    input  logic [31:0]            HADDR,
    input  logic [1:0]             HTRANS,
    input  logic                   HWRITE,
    input  logic [2:0]             HSIZE,
    input  logic [31:0]            HWDATA,
    input  logic                   HREADY,
    output logic                   HREADYOUT,
    output logic                   HRESP,
    output logic [31:0]            HRDATA,
    output logic [NSLAVE-1:0]      PSEL,
    output logic                   PENABLE,
    output logic                   PWRITE,
    output logic [PADDR_WIDTH-1:0] PADDR,
    output logic [31:0]            PWDATA,
    input  logic [31:0]            PRDATA,
    input  logic                   PREADY,
    input  logic                   PSLVERR,
    output state_e                 dbg_state
);

    localparam logic [SELW:0] NSLAVE_W = (SELW + 1)'(NSLAVE);

    state_e                 state_q, state_d;
    logic                   hreadyout_q, hreadyout_d;
    logic                   hresp_q, hresp_d;
    logic [31:0]            hrdata_q, hrdata_d;
    logic [NSLAVE-1:0]      psel_q, psel_d;
    logic                   penable_q, penable_d;
    logic                   pwrite_q, pwrite_d;
    logic [PADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic [31:0]            pwdata_q, pwdata_d;
    logic [PADDR_WIDTH-1:0] addr_q, addr_d;
    logic                   write_q, write_d;
    logic [SELW-1:0]        idx_q, idx_d;

    logic [SELW-1:0] hidx;
    logic            trans_active, accept, legal;
    logic            tmr_clr, tmr_en, tmr_expired;
    logic            unused_hbits;

    assign hidx         = HADDR[PADDR_WIDTH+SELW-1:PADDR_WIDTH];
    assign trans_active = (HTRANS == HTRANS_NONSEQ) || (HTRANS == HTRANS_SEQ);
    assign accept       = HSEL && HREADY && trans_active && hreadyout_q;
    assign legal        = (HSIZE == HSIZE_WORD) && ({1'b0, hidx} < NSLAVE_W);
    assign unused_hbits = ^HADDR[31:PADDR_WIDTH+SELW];
    assign tmr_clr      = (state_q == SETUP);
    assign tmr_en       = (state_q == ACCESS);

    apb_timeout_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk     (HCLK),
        .rst     (HRESET),
        .clr     (tmr_clr),
        .en      (tmr_en),
        .expired (tmr_expired)
    );

    always_comb begin
        state_d     = state_q;
        hreadyout_d = hreadyout_q;
        hresp_d     = hresp_q;
        hrdata_d    = hrdata_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        addr_d      = addr_q;
        write_d     = write_q;
        idx_d       = idx_q;
        case (state_q)
            // ERR2 ends the error response; its closing edge may already accept the next transfer.
            IDLE, ERR2: begin
                state_d     = IDLE;
                hreadyout_d = 1'b1;
                hresp_d     = HRESP_OKAY;
                if (accept) begin
                    addr_d      = HADDR[PADDR_WIDTH-1:0];
                    write_d     = HWRITE;
                    idx_d       = hidx;
                    hreadyout_d = 1'b0;
                    if (legal) begin
                        state_d = WDAT;
                    end else begin
                        state_d = ERR1;
                        hresp_d = HRESP_ERROR;
                    end
                end
            end
            WDAT: begin
                if (write_q) begin
                    pwdata_d = HWDATA;
                end
                paddr_d  = addr_q;
                pwrite_d = write_q;
                psel_d   = NSLAVE'(1) << idx_q;
                state_d  = SETUP;
            end
            SETUP: begin
                penable_d = 1'b1;
                state_d   = ACCESS;
            end
            ACCESS: begin
                if (PREADY) begin
                    psel_d    = '0;
                    penable_d = 1'b0;
                    if (PSLVERR) begin
                        hresp_d = HRESP_ERROR;
                        state_d = ERR1;
                    end else begin
                        if (!write_q) begin
                            hrdata_d = PRDATA;
                        end
                        hreadyout_d = 1'b1;
                        state_d     = IDLE;
                    end
                end else if (tmr_expired) begin
                    psel_d    = '0;
                    penable_d = 1'b0;
                    hresp_d   = HRESP_ERROR;
                    state_d   = ERR1;
                end
            end
            ERR1: begin
                hreadyout_d = 1'b1;
                state_d     = ERR2;
            end
            default: begin
                state_d     = IDLE;
                hreadyout_d = 1'b1;
                hresp_d     = HRESP_OKAY;
                psel_d      = '0;
                penable_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q     <= IDLE;
            hreadyout_q <= 1'b1;
            hresp_q     <= HRESP_OKAY;
            hrdata_q    <= '0;
            psel_q      <= '0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            addr_q      <= '0;
            write_q     <= 1'b0;
            idx_q       <= '0;
        end else begin
            state_q     <= state_d;
            hreadyout_q <= hreadyout_d;
            hresp_q     <= hresp_d;
            hrdata_q    <= hrdata_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            addr_q      <= addr_d;
            write_q     <= write_d;
            idx_q       <= idx_d;
        end
    end

    assign HREADYOUT = hreadyout_q;
    assign HRESP     = hresp_q;
    assign HRDATA    = hrdata_q;
    assign PSEL      = psel_q;
    assign PENABLE   = penable_q;
    assign PWRITE    = pwrite_q;
    assign PADDR     = paddr_q;
    assign PWDATA    = pwdata_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_ahbl_apb_bridge.sv
// Self-checking bench for ahbl_apb_bridge: directed scenarios plus randomized transfers against a
// transaction-level model of data-phase length, response, PSEL and read data.
module tb_ahbl_apb_bridge;
    import ahbl_apb_pkg::*;

    localparam int PW   = 12;
    localparam int SELW = 4;
    localparam int NS   = 8;
    localparam int TO   = 8;

    logic          HCLK = 1'b0;
    logic          HRESET = 1'b1;
    logic          HSEL = 1'b0;
    logic [31:0]   HADDR = '0;
    logic [1:0]    HTRANS = 2'b00;
    logic          HWRITE = 1'b0;
    logic [2:0]    HSIZE = 3'b010;
    logic [31:0]   HWDATA = '0;
    logic          HREADY = 1'b1;
    logic          HREADYOUT, HRESP, PENABLE, PWRITE;
    logic [31:0]   HRDATA, PWDATA;
    logic [NS-1:0] PSEL;
    logic [PW-1:0] PADDR;
    logic [31:0]   PRDATA = '0;
    logic          PREADY = 1'b0;
    logic          PSLVERR = 1'b0;
    state_e        dbg_state;

    int          checks = 0;
    int          failures = 0;
    int          cfg_wait = 0;
    logic        cfg_err = 1'b0;
    logic [31:0] cfg_rdata = '0;
    int          acc_k = 0;
    logic [31:0] m_hrdata = '0;
    logic [31:0] m_pwdata = '0;

    ahbl_apb_bridge #(.PADDR_WIDTH(PW), .SELW(SELW), .NSLAVE(NS), .TIMEOUT(TO)) dut (
        .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
        .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA), .HREADY(HREADY),
        .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA), .PSEL(PSEL),
        .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR), .dbg_state(dbg_state)
    );

    always #5 HCLK = ~HCLK;

    // APB slave: ready on ACCESS cycle index cfg_wait (never if negative); junk otherwise.
    always @(negedge HCLK) begin
        if (HRESET || !(PENABLE && PSEL != '0)) begin
            acc_k   = 0;
            PREADY  = 1'b0;
            PSLVERR = 1'b0;
            PRDATA  = $urandom;
        end else begin
            if (cfg_wait >= 0 && acc_k >= cfg_wait) begin
                PREADY  = 1'b1;
                PSLVERR = cfg_err;
                PRDATA  = cfg_rdata;
            end else begin
                PREADY  = 1'b0;
                PSLVERR = 1'($urandom);
                PRDATA  = $urandom;
            end
            acc_k++;
        end
    end

    task automatic drive_addr(input logic [31:0] a, input logic wr, input logic [2:0] sz);
        HSEL   = 1'b1;
        HADDR  = a;
        HWRITE = wr;
        HSIZE  = sz;
        HTRANS = HTRANS_NONSEQ;
    endtask

    task automatic gap();
        HTRANS = HTRANS_IDLE;
        @(negedge HCLK);
    endtask

    // Completes a transfer whose address phase is already driven; data-phase length counts
    // the final HREADYOUT-high cycle. Returns on that cycle's falling edge.
    task automatic finish_xfer(input string name, input logic [31:0] a, input logic wr,
                               input logic [2:0] sz, input logic [31:0] wd, input int w,
                               input logic err, input logic [31:0] rd);
        int            idx, acc, exp_len, n, en_cycles, bad_onehot, bad_stable, resp_early;
        logic          legal, ready, exp_resp, seen_high, last_low_resp;
        logic [NS-1:0] exp_psel, psel_or;
        idx   = int'(a[PW+SELW-1:PW]);
        legal = (sz == HSIZE_WORD) && (idx < NS);
        ready = (w >= 0) && (w < TO);
        if (!legal) begin
            acc = 0; exp_len = 2; exp_resp = 1'b1;
        end else if (ready && !err) begin
            acc = w + 1; exp_len = acc + 3; exp_resp = 1'b0;
        end else begin
            acc = ready ? w + 1 : TO; exp_len = acc + 4; exp_resp = 1'b1;
        end
        exp_psel = legal ? (NS'(1) << idx) : '0;
        if (legal && wr) m_pwdata = wd;
        cfg_wait = w; cfg_err = err; cfg_rdata = rd;
        n = 0; en_cycles = 0; bad_onehot = 0; bad_stable = 0; resp_early = 0;
        seen_high = 1'b0; last_low_resp = 1'b0; psel_or = '0;
        @(posedge HCLK);
        #1;
        HTRANS = HTRANS_IDLE;
        HWDATA = wd;
        while (!seen_high && n < 64) begin
            @(negedge HCLK);
            n++;
            psel_or |= PSEL;
            if (!$onehot0(PSEL)) bad_onehot++;
            if (PENABLE) en_cycles++;
            if (PSEL != '0 && (PADDR !== a[PW-1:0] || PWRITE !== wr || PWDATA !== m_pwdata))
                bad_stable++;
            if (HREADYOUT) begin
                seen_high = 1'b1;
            end else begin
                last_low_resp = HRESP;
                if (HRESP && n < exp_len - 1) resp_early++;
            end
        end
        if (legal && ready && !err && !wr) m_hrdata = rd;

        checks++; if (n !== exp_len) begin failures++;
            $display("FAIL %s data_phase_len got=%0d exp=%0d", name, n, exp_len); end
        checks++; if (HRESP !== exp_resp) begin failures++;
            $display("FAIL %s final_hresp got=%0b exp=%0b", name, HRESP, exp_resp); end
        checks++; if (last_low_resp !== exp_resp) begin failures++;
            $display("FAIL %s err1_hresp got=%0b exp=%0b", name, last_low_resp, exp_resp); end
        checks++; if (resp_early !== 0) begin failures++;
            $display("FAIL %s early_hresp got=%0d exp=0", name, resp_early); end
        checks++; if (psel_or !== exp_psel) begin failures++;
            $display("FAIL %s psel got=%0h exp=%0h", name, psel_or, exp_psel); end
        checks++; if (bad_onehot !== 0) begin failures++;
            $display("FAIL %s psel_onehot got=%0d exp=0", name, bad_onehot); end
        checks++; if (bad_stable !== 0) begin failures++;
            $display("FAIL %s apb_stable got=%0d exp=0", name, bad_stable); end
        checks++; if (en_cycles !== acc) begin failures++;
            $display("FAIL %s access_cycles got=%0d exp=%0d", name, en_cycles, acc); end
        checks++; if (PSEL !== '0 || PENABLE !== 1'b0) begin failures++;
            $display("FAIL %s psel_released got=%0h/%0b exp=0/0", name, PSEL, PENABLE); end
        checks++; if (HRDATA !== m_hrdata) begin failures++;
            $display("FAIL %s hrdata got=%0h exp=%0h", name, HRDATA, m_hrdata); end
    endtask

    task automatic check_reset_outputs(input string name);
        checks++;
        if ({HREADYOUT, HRESP, HRDATA, PSEL, PENABLE, PWRITE, PADDR, PWDATA} !==
            {1'b1, 1'b0, 32'h0, {NS{1'b0}}, 1'b0, 1'b0, {PW{1'b0}}, 32'h0}) begin
            failures++;
            $display("FAIL %s outputs got=%b/%b/%0h/%0h/%b/%b/%0h/%0h exp=1/0/0/0/0/0/0/0", name,
                     HREADYOUT, HRESP, HRDATA, PSEL, PENABLE, PWRITE, PADDR, PWDATA);
        end
        checks++;
        if (dbg_state !== IDLE) begin failures++;
            $display("FAIL %s state got=%0d exp=%0d", name, dbg_state, IDLE); end
    endtask

    task automatic test_reset();
        #2;
        check_reset_outputs("reset");
        repeat (2) @(negedge HCLK);
        HRESET = 1'b0;
        @(negedge HCLK);
        check_reset_outputs("post_reset");
    endtask

    task automatic test_idle_busy();
        HSEL = 1'b1; HADDR = 32'h0000_3010; HSIZE = HSIZE_WORD;
        HTRANS = HTRANS_BUSY;
        repeat (2) @(negedge HCLK);
        HTRANS = HTRANS_IDLE;
        repeat (2) @(negedge HCLK);
        HTRANS = HTRANS_NONSEQ; HREADY = 1'b0;
        repeat (2) @(negedge HCLK);
        HREADY = 1'b1; HSEL = 1'b0;
        repeat (2) @(negedge HCLK);
        HSEL = 1'b1; HTRANS = HTRANS_IDLE;
        check_reset_outputs("idle_busy");
    endtask

    task automatic test_write_read();
        drive_addr(32'h0000_3010, 1'b1, HSIZE_WORD);
        finish_xfer("write", 32'h0000_3010, 1'b1, HSIZE_WORD, 32'hA5A5_1234, 0, 1'b0, 32'h0);
        checks++; if (PWDATA !== 32'hA5A5_1234) begin failures++;
            $display("FAIL write pwdata got=%0h exp=a5a51234", PWDATA); end
        gap();
        drive_addr(32'h0000_3010, 1'b0, HSIZE_WORD);
        finish_xfer("read", 32'h0000_3010, 1'b0, HSIZE_WORD, 32'h1111_2222, 0, 1'b0, 32'hDEAD_BEEF);
        checks++; if (HRDATA !== 32'hDEAD_BEEF) begin failures++;
            $display("FAIL read hrdata got=%0h exp=deadbeef", HRDATA); end
        gap();
    endtask

    task automatic test_wait_states();
        drive_addr(32'h0000_5ABC, 1'b0, HSIZE_WORD);
        finish_xfer("wait5", 32'h0000_5ABC, 1'b0, HSIZE_WORD, 32'h0, 5, 1'b0, 32'h0BAD_F00D);
        gap();
    endtask

    task automatic test_slverr();
        drive_addr(32'h0000_1004, 1'b0, HSIZE_WORD);
        finish_xfer("slverr_rd", 32'h0000_1004, 1'b0, HSIZE_WORD, 32'h0, 0, 1'b1, 32'h5555_AAAA);
        gap();
        drive_addr(32'h0000_7008, 1'b1, HSIZE_WORD);
        finish_xfer("slverr_wr", 32'h0000_7008, 1'b1, HSIZE_WORD, 32'h0F0F_0F0F, 2, 1'b1, 32'h0);
        gap();
    endtask

    task automatic test_timeout();
        drive_addr(32'h0000_2FFC, 1'b0, HSIZE_WORD);
        finish_xfer("timeout_rd", 32'h0000_2FFC, 1'b0, HSIZE_WORD, 32'h0, -1, 1'b0, 32'h1234_5678);
        gap();
        drive_addr(32'h0000_6000, 1'b1, HSIZE_WORD);
        finish_xfer("timeout_edge", 32'h0000_6000, 1'b1, HSIZE_WORD, 32'hCAFE_0001, 7, 1'b0, 32'h0);
        gap();
    endtask

    task automatic test_illegal();
        drive_addr(32'h0000_1010, 1'b1, 3'b000);
        finish_xfer("bad_size", 32'h0000_1010, 1'b1, 3'b000, 32'h7777_7777, 0, 1'b0, 32'h0);
        gap();
        drive_addr(32'h0000_C020, 1'b0, HSIZE_WORD);
        finish_xfer("bad_idx", 32'h0000_C020, 1'b0, HSIZE_WORD, 32'h0, 0, 1'b0, 32'h9999_9999);
        gap();
    endtask

    task automatic test_back_to_back();
        drive_addr(32'h0000_2040, 1'b1, HSIZE_WORD);
        finish_xfer("b2b_wr", 32'h0000_2040, 1'b1, HSIZE_WORD, 32'h0102_0304, 0, 1'b0, 32'h0);
        drive_addr(32'h0000_6044, 1'b0, HSIZE_WORD);
        finish_xfer("b2b_rd", 32'h0000_6044, 1'b0, HSIZE_WORD, 32'h0, 0, 1'b0, 32'hFEED_FACE);
        drive_addr(32'h0000_E000, 1'b1, HSIZE_WORD);
        finish_xfer("b2b_err", 32'h0000_E000, 1'b1, HSIZE_WORD, 32'h0, 0, 1'b0, 32'h0);
        drive_addr(32'h0000_0048, 1'b0, HSIZE_WORD);
        finish_xfer("b2b_after_err", 32'h0000_0048, 1'b0, HSIZE_WORD, 32'h0, 1, 1'b0, 32'h600D_CAFE);
        gap();
    endtask

    task automatic test_reset_in_access();
        cfg_wait = -1; cfg_err = 1'b0; cfg_rdata = '0;
        drive_addr(32'h0000_4020, 1'b0, HSIZE_WORD);
        @(posedge HCLK);
        #1;
        HTRANS = HTRANS_IDLE;
        repeat (4) @(negedge HCLK);
        checks++; if (PENABLE !== 1'b1 || PSEL !== 8'h10) begin failures++;
            $display("FAIL rst_access in_access got=%0b/%0h exp=1/10", PENABLE, PSEL); end
        #2;
        HRESET = 1'b1;
        #1;
        check_reset_outputs("rst_access");
        @(negedge HCLK);
        HRESET = 1'b0;
        m_hrdata = '0; m_pwdata = '0;
        @(negedge HCLK);
        drive_addr(32'h0000_1100, 1'b1, HSIZE_WORD);
        finish_xfer("post_rst", 32'h0000_1100, 1'b1, HSIZE_WORD, 32'h4242_4242, 1, 1'b0, 32'h0);
        gap();
    endtask

    task automatic test_random();
        logic [31:0] a, wd, rd;
        logic        wr, err;
        logic [2:0]  sz;
        int          w;
        for (int i = 0; i < 30; i++) begin
            a   = {16'($urandom), 4'($urandom_range(0, 9)), 12'($urandom)};
            wr  = 1'($urandom);
            sz  = ($urandom_range(0, 5) == 0) ? 3'b000 : HSIZE_WORD;
            w   = int'($urandom_range(0, 10)) - 1;
            err = ($urandom_range(0, 3) == 0);
            wd  = $urandom;
            rd  = $urandom;
            if (i > 0 && $urandom_range(0, 1) == 0) gap();
            drive_addr(a, wr, sz);
            finish_xfer($sformatf("rand%0d", i), a, wr, sz, wd, w, err, rd);
        end
        gap();
    endtask

    initial begin
        @(negedge HCLK);
        test_reset();
        test_idle_busy();
        test_write_read();
        test_wait_states();
        test_slverr();
        test_timeout();
        test_illegal();
        test_back_to_back();
        test_reset_in_access();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
